// File: rtl/dlock_code_driver.sv
// Feeds a parallel code word to the digital lock: clears the lock, shifts the code out MSB-first,
// samples unlock after a settle delay and reports the result with a done pulse and pass flag.
module dlock_code_driver #(
  parameter int unsigned CODE_W = 6,
  parameter int unsigned SETTLE = 1
) (
  input  logic              clk,
  input  logic              clear,
  input  logic [CODE_W-1:0] code_in,
  input  logic              code_valid,
  output logic              code_ready,
  output logic              b_out,
  output logic              lock_clr,
  input  logic              unlock,
  output logic              done,
  output logic              pass
);

  localparam int unsigned BitCntW = $clog2(CODE_W + 1);
  localparam int unsigned SetCntW = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StShift,
    StWait,
    StReport
  } state_e;

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   shreg_q, shreg_d;
  logic [BitCntW-1:0]  bitcnt_q, bitcnt_d;
  logic [SetCntW-1:0]  setcnt_q, setcnt_d;
  logic                b_out_q, b_out_d;
  logic                pass_q, pass_d;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q  <= StIdle;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      setcnt_q <= '0;
      b_out_q  <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      setcnt_q <= setcnt_d;
      b_out_q  <= b_out_d;
      pass_q   <= pass_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    setcnt_d = setcnt_q;
    pass_d   = pass_q;
    unique case (state_q)
      StIdle: begin
        if (code_valid) begin
          shreg_d  = code_in;
          bitcnt_d = BitCntW'(CODE_W);
          pass_d   = 1'b0;
          state_d  = StClr;
        end
      end
      StClr: state_d = StShift;
      StShift: begin
        shreg_d  = shreg_q << 1;
        bitcnt_d = bitcnt_q - BitCntW'(1);
        if (bitcnt_q == BitCntW'(1)) begin
          setcnt_d = SetCntW'(SETTLE);
          state_d  = StWait;
        end
      end
      StWait: begin
        setcnt_d = setcnt_q - SetCntW'(1);
        if (setcnt_q == SetCntW'(1)) begin
          pass_d  = unlock;
          state_d = StReport;
        end
      end
      StReport: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    // Register the bit for the upcoming cycle so it is stable well before the lock's negedge.
    b_out_d = (state_d == StShift) ? shreg_d[CODE_W-1] : 1'b0;
  end

  // Gated by clear so the lock is held in reset together with this block.
  assign code_ready = clear && (state_q == StIdle);
  assign lock_clr   = clear && (state_q != StClr);
  assign done       = (state_q == StReport);
  assign b_out      = b_out_q;
  assign pass       = pass_q;

endmodule

// File: tb/tb_dlock_code_driver.sv
// Directed bench for dlock_code_driver with a behavioural lock model that opens on 6'b101100.
module tb_dlock_code_driver;

  localparam logic [5:0] Secret = 6'b101100;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic [5:0] code_in = '0, code_in3 = '0;
  logic       code_valid = 1'b0, code_valid3 = 1'b0;
  logic       code_ready, b_out, lock_clr, unlock, done, pass;
  logic       code_ready3, b_out3, lock_clr3, unlock3, done3, pass3;

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dlock_code_driver #(.CODE_W(6), .SETTLE(1)) dut (
    .clk(clk), .clear(clear), .code_in(code_in), .code_valid(code_valid),
    .code_ready(code_ready), .b_out(b_out), .lock_clr(lock_clr), .unlock(unlock),
    .done(done), .pass(pass)
  );

  dlock_code_driver #(.CODE_W(6), .SETTLE(3)) dut3 (
    .clk(clk), .clear(clear), .code_in(code_in3), .code_valid(code_valid3),
    .code_ready(code_ready3), .b_out(b_out3), .lock_clr(lock_clr3), .unlock(unlock3),
    .done(done3), .pass(pass3)
  );

  // Lock model: takes the first six bits after a clear on negedge, opens on a match.
  logic [5:0] m_hist = '0, m_hist3 = '0;
  int         m_cnt = 0, m_cnt3 = 0;

  always @(negedge clk) begin
    if (!lock_clr) begin
      m_hist <= '0;
      m_cnt  <= 0;
    end else if (m_cnt < 6) begin
      m_hist <= {m_hist[4:0], b_out};
      m_cnt  <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (!lock_clr3) begin
      m_hist3 <= '0;
      m_cnt3  <= 0;
    end else if (m_cnt3 < 6) begin
      m_hist3 <= {m_hist3[4:0], b_out3};
      m_cnt3  <= m_cnt3 + 1;
    end
  end

  assign unlock  = (m_cnt == 6) && (m_hist == Secret);
  assign unlock3 = (m_cnt3 == 6) && (m_hist3 == Secret);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transfer on the SETTLE=1 instance; accept happens on the next edge.
  task automatic run(input logic [5:0] code, input logic exp_pass, input bit hold,
                     input bit noise);
    code_in    = code;
    code_valid = 1'b1;
    step();
    chk("clr_lock_clr", {31'b0, lock_clr}, 32'd0);
    chk("clr_b_out", {31'b0, b_out}, 32'd0);
    chk("clr_ready", {31'b0, code_ready}, 32'd0);
    chk("clr_pass_cleared", {31'b0, pass}, 32'd0);
    code_valid = hold;
    for (int i = 5; i >= 0; i--) begin
      step();
      chk($sformatf("bit%0d", i), {31'b0, b_out}, {31'b0, code[i]});
      chk("shift_lock_clr", {31'b0, lock_clr}, 32'd1);
      chk("shift_ready", {31'b0, code_ready}, 32'd0);
      if (noise) begin
        code_in    = 6'($urandom);
        code_valid = 1'($urandom_range(0, 1));
      end
    end
    code_valid = hold;
    step();
    chk("wait_done", {31'b0, done}, 32'd0);
    chk("wait_b_out", {31'b0, b_out}, 32'd0);
    step();
    chk("done_pulse", {31'b0, done}, 32'd1);
    chk("done_ready", {31'b0, code_ready}, 32'd0);
    chk("pass", {31'b0, pass}, {31'b0, exp_pass});
    step();
    chk("idle_done", {31'b0, done}, 32'd0);
    chk("idle_ready", {31'b0, code_ready}, 32'd1);
    chk("idle_pass_hold", {31'b0, pass}, {31'b0, exp_pass});
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_ready", {31'b0, code_ready}, 32'd0);
    chk("rst_lock_clr", {31'b0, lock_clr}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_pass", {31'b0, pass}, 32'd0);
    chk("rst_b_out", {31'b0, b_out}, 32'd0);
    #20 clear = 1'b1;
    step();
    chk("rel_ready", {31'b0, code_ready}, 32'd1);
    chk("rel_lock_clr", {31'b0, lock_clr}, 32'd1);

    // Reset during the third shifted bit
    code_in    = Secret;
    code_valid = 1'b1;
    step();
    code_valid = 1'b0;
    step();
    step();
    step();
    chk("mid_b_out_pre", {31'b0, b_out}, 32'd1);
    clear = 1'b0;
    #1;
    chk("mid_lock_clr", {31'b0, lock_clr}, 32'd0);
    chk("mid_b_out", {31'b0, b_out}, 32'd0);
    chk("mid_ready", {31'b0, code_ready}, 32'd0);
    chk("mid_done", {31'b0, done}, 32'd0);
    #2 clear = 1'b1;
    step();
    chk("mid_rel_ready", {31'b0, code_ready}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("mid_no_done", {31'b0, done}, 32'd0);
      step();
    end

    // Correct code, wrong code, back-to-back with valid held, noise while busy
    run(Secret, 1'b1, 1'b0, 1'b0);
    run(6'b101101, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("pass_stays_0", {31'b0, pass}, 32'd0);
    end
    run(Secret, 1'b1, 1'b1, 1'b0);
    run(6'b000000, 1'b0, 1'b0, 1'b0);
    run(Secret, 1'b1, 1'b0, 1'b1);

    // SETTLE=3 instance
    code_in3    = Secret;
    code_valid3 = 1'b1;
    step();
    code_valid3 = 1'b0;
    chk("s3_clr", {31'b0, lock_clr3}, 32'd0);
    for (int e = 1; e <= 9; e++) begin
      step();
      if (e <= 6) chk($sformatf("s3_bit_e%0d", e), {31'b0, b_out3}, {31'b0, Secret[6-e]});
      chk($sformatf("s3_no_done_e%0d", e), {31'b0, done3}, 32'd0);
    end
    step();
    chk("s3_done", {31'b0, done3}, 32'd1);
    chk("s3_pass", {31'b0, pass3}, 32'd1);
    step();
    chk("s3_done_end", {31'b0, done3}, 32'd0);
    chk("s3_ready", {31'b0, code_ready3}, 32'd1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
